// File: rtl/fast_window_7x7.sv
// 7x7 neighbourhood builder for the FAST circle sampler: six line buffers feed a
// shifting 7x7 register window, flagged valid only when every pixel is inside the frame.
module fast_window_7x7 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 pix_valid,
  input  logic                                 pix_sof,
  input  logic [DATA_WIDTH-1:0]                pix_data,
  output logic                                 window_valid,
  output logic [0:6][0:6][DATA_WIDTH-1:0]      window,
  output logic [$clog2(IMG_WIDTH)-1:0]         win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0]        win_y,
  output logic                                 frame_done
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  logic [XW-1:0]         x, cur_x;
  logic [YW-1:0]         y, cur_y;
  logic                  x_last, y_last, interior;
  logic [DATA_WIDTH-1:0] col [0:6];
  logic [DATA_WIDTH-1:0] lb  [0:5][0:IMG_WIDTH-1];

  // A start-of-frame pixel is forced to (0,0) regardless of the counters.
  assign cur_x    = pix_sof ? '0 : x;
  assign cur_y    = pix_sof ? '0 : y;
  assign x_last   = (cur_x == X_LAST);
  assign y_last   = (cur_y == Y_LAST);
  assign interior = (cur_x >= XW'(6)) && (cur_y >= YW'(6));

  always_comb begin
    col[0] = pix_data;
    for (int k = 1; k < 7; k++) begin
      col[k] = lb[k-1][cur_x];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (pix_valid) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : cur_y + YW'(1);
      end else begin
        x <= cur_x + XW'(1);
        y <= cur_y;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      win_x        <= '0;
      win_y        <= '0;
    end else begin
      window_valid <= pix_valid && interior;
      frame_done   <= pix_valid && x_last && y_last;
      if (pix_valid && interior) begin
        win_x <= cur_x - XW'(3);
        win_y <= cur_y - YW'(3);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window <= '0;
    end else if (pix_valid) begin
      for (int r = 0; r < 7; r++) begin
        for (int c = 0; c < 6; c++) begin
          window[r][c] <= window[r][c+1];
        end
        window[r][6] <= col[r];
      end
    end
  end

  // Line-buffer RAM carries no reset so it can map onto block memory.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb[0][cur_x] <= pix_data;
      for (int k = 1; k < 6; k++) begin
        lb[k][cur_x] <= col[k];
      end
    end
  end

endmodule

// File: tb/tb_fast_window_7x7.sv
// Randomized self-checking bench for fast_window_7x7 on a 16x12 frame, checked
// against a frame-image reference model that knows nothing about line buffers.
module tb_fast_window_7x7;

  localparam int W = 16;
  localparam int H = 12;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   pix_valid = 1'b0;
  logic                   pix_sof = 1'b0;
  logic [7:0]             pix_data = '0;
  logic                   window_valid;
  logic [0:6][0:6][7:0]   window;
  logic [3:0]             win_x;
  logic [3:0]             win_y;
  logic                   frame_done;

  int img [0:H-1][0:W-1];
  int mx = 0, my = 0;
  int pulse_count = 0, done_count = 0;
  int checks = 0, failures = 0;
  bit formula_mode = 1'b0;

  fast_window_7x7 #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
    .window_valid(window_valid), .window(window), .win_x(win_x), .win_y(win_y),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Drive one cycle of input, advance the reference model, then check outputs after the edge.
  task automatic applyStimulus(input bit v, input bit s, input logic [7:0] d);
    int px, py;
    bit ev, ed;
    @(negedge clk);
    pix_valid = v;
    pix_sof   = s;
    pix_data  = d;
    ev = 1'b0; ed = 1'b0; px = 0; py = 0;
    if (v) begin
      if (s) begin mx = 0; my = 0; end
      px = mx; py = my;
      img[py][px] = d;
      ev = (px >= 6) && (py >= 6);
      ed = (px == W-1) && (py == H-1);
      if (mx == W-1) begin
        mx = 0;
        my = (my == H-1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("window_valid", window_valid, ev);
    checkOutput("frame_done", frame_done, ed);
    if (ev) begin
      pulse_count++;
      checkOutput("win_x", win_x, px - 3);
      checkOutput("win_y", win_y, py - 3);
      for (int r = 0; r < 7; r++)
        for (int c = 0; c < 7; c++)
          checkOutput($sformatf("window[%0d][%0d] at (%0d,%0d)", r, c, px, py),
                      window[r][c], img[py-r][px-6+c]);
      if (formula_mode && px == 6 && py == 6) begin
        checkOutput("first_w33", window[3][3], 51);
        checkOutput("first_w06", window[0][6], 102);
        checkOutput("first_w60", window[6][0], 0);
      end
      if (formula_mode && px == 6 && py == 7) begin
        checkOutput("wrap_w00", window[0][0], 112);
        checkOutput("wrap_w66", window[6][6], 22);
      end
    end
    if (ed) done_count++;
  endtask

  task automatic run_frame(input int npix, input int bubble_pct, input bit first_sof, input bit formula);
    logic [7:0] d;
    formula_mode = formula;
    for (int i = 0; i < npix; i++) begin
      for (int b = 0; b < 3 && $urandom_range(99) < bubble_pct; b++)
        applyStimulus(1'b0, 1'($urandom_range(1)), 8'($urandom));
      d = formula ? 8'((16 * (i / W) + (i % W)) % 256) : 8'($urandom);
      applyStimulus(1'b1, first_sof && (i == 0), d);
    end
  endtask

  task automatic check_zero(input string tag);
    checkOutput({tag, "_valid"}, window_valid, 0);
    checkOutput({tag, "_done"}, frame_done, 0);
    checkOutput({tag, "_win_x"}, win_x, 0);
    checkOutput({tag, "_win_y"}, win_y, 0);
    checkOutput({tag, "_window"}, 32'(|window), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Clean contiguous frame with sof.
    pulse_count = 0; done_count = 0;
    run_frame(W*H, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("clean_pulses", pulse_count, 60);
    checkOutput("clean_done", done_count, 1);

    // Same frame with ~40% bubbles, then a random-data frame.
    pulse_count = 0; done_count = 0;
    run_frame(W*H, 40, 1'b1, 1'b1);
    run_frame(W*H, 40, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("bubble_pulses", pulse_count, 120);
    checkOutput("bubble_done", done_count, 2);

    // Abort after pixel (9,8), then restart with sof.
    done_count = 0;
    run_frame(8*W + 10, 20, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("abort_done", done_count, 0);
    pulse_count = 0; done_count = 0;
    run_frame(W*H, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("restart_pulses", pulse_count, 60);
    checkOutput("restart_done", done_count, 1);

    // Async reset between edges while a valid window is being presented in row 7.
    run_frame(7*W + 9, 0, 1'b1, 1'b1);
    checkOutput("pre_reset_valid", window_valid, 1);
    pix_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero("async");
    mx = 0; my = 0;
    @(negedge clk);
    rst = 1'b0;
    pulse_count = 0; done_count = 0;
    run_frame(W*H, 30, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("post_reset_pulses", pulse_count, 60);
    checkOutput("post_reset_done", done_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fast_window_7x7.md
# fast_window_7x7

Builds the 7x7 pixel neighbourhood consumed by `fast_circle_sampler` from a raster-order grayscale pixel stream. The block holds six line buffers plus a 7x7 register array and raises `window_valid` only for fully interior windows, where all 49 pixels lie inside the frame. Each valid window is tagged with its centre coordinate. It sits directly upstream of the FAST circle sampler in the feature-extractor pipeline.

## Interface
- `DATA_WIDTH`, 8, pixel width in bits
- `IMG_WIDTH`, 640, pixels per row (must be ≥ 7)
- `IMG_HEIGHT`, 480, rows per frame (must be ≥ 7)
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pix_valid`  in  1  pixel accepted on this edge; no backpressure
- `pix_sof`  in  1  qualifies `pix_valid`; this pixel is (0,0) of a new frame
- `pix_data`  in  DATA_WIDTH  pixel value
- `window_valid`  out  1  one-cycle strobe; window and coordinates valid
- `window[0:6][0:6]`  out  DATA_WIDTH each  neighbourhood; row 0 = newest row, column 6 = newest column
- `win_x`  out  $clog2(IMG_WIDTH)  centre column (x−3)
- `win_y`  out  $clog2(IMG_HEIGHT)  centre row (y−3)
- `frame_done`  out  1  one-cycle strobe after the last pixel of a frame is accepted

## Operation
- Counters `x`, `y` give the position of the pixel being accepted. Reset value is (0,0), so `pix_sof` is optional for the first frame.
- Pixel accepted with `pix_sof=1`:
  - The pixel is treated as (0,0), whatever the counter values.
  - A mid-frame `pix_sof` aborts the current frame silently. No `frame_done` is generated for it.
- Otherwise, on each accepted pixel:
  - If `x=IMG_WIDTH−1`, then x→0 and y increments.
  - If additionally `y=IMG_HEIGHT−1`, then y→0 and `frame_done` fires.
- Line buffers: six rows of IMG_WIDTH entries, `lb[0]`..`lb[5]`, where `lb[k][x]` holds row y−1−k. They are not reset; their contents are don't-care until overwritten.
- On an accepted pixel at column x:
  - Form the column vector `col[0]=pix_data`, `col[k]=lb[k−1][x]` for k=1..6.
  - Write back `lb[0][x]←pix_data` and `lb[k][x]←lb[k−1][x]`.
- Window shift, on accepted pixels only:
  - `window[r][c]←window[r][c+1]` for c=0..5.
  - `window[r][6]←col[r]`.
- Validity:
  - `window_valid←1` iff the accepted pixel has x≥6 and y≥6; the next cycle also registers `win_x=x−3`, `win_y=y−3`.
  - Windows straddling a row boundary (x<6) are never flagged valid.
  - Windows containing pre-frame or stale line-buffer rows (y<6) are never flagged valid.
- Coordinate arithmetic is unsigned, in counter widths; subtraction only occurs when the result is ≥ 3, so it never underflows.

## Timing
- Latency is 1 cycle. A pixel accepted at edge t is visible at `window[0][6]`, with `window_valid` high, during the cycle after edge t.
- `window_valid` and `frame_done` are single-cycle strobes and are low in any cycle that follows a non-accepting edge.
- Bubbles (`pix_valid=0`):
  - Counters, line buffers, `window`, `win_x` and `win_y` all hold.
  - The window sequence is independent of bubble placement.
- `frame_done` and the final `window_valid` of a frame (centre (IMG_WIDTH−4, IMG_HEIGHT−4)) assert in the same cycle.
- Reset (asserted at any time, including mid-frame), takes effect immediately and asynchronously:
  - `window_valid`, `frame_done`, `win_x`, `win_y`, all `window` entries and the x/y counters are cleared to 0.
  - Line-buffer RAM is not cleared.
- After reset deasserts, the first accepted pixel is (0,0).
- `pix_sof` with `pix_valid=0` is ignored.

## Test plan
Parameters for all benches: IMG_WIDTH=16, IMG_HEIGHT=12, pixel value = (16y+x) mod 256.
- **Reset:** assert `rst` with no input → all outputs 0. Release, then feed a pixel → no `window_valid` until pixel (6,6).
- **Full contiguous frame** with `pix_sof` on the first pixel:
  - Exactly 60 `window_valid` pulses.
  - First pulse one cycle after pixel (6,6): `win_x=3`, `win_y=3`, `window[3][3]=51`, `window[0][6]=102`, `window[6][0]=0`.
  - Last pulse has centre (12,8) and coincides with `frame_done`.
- **Row wrap:** no pulses for pixels x=0..5 of row 7. The pulse after pixel (6,7) has `window[0][0]=112`, `window[6][6]=22` and centre (3,4).
- **Random bubbles** (≈40% `pix_valid=0`) over a full frame → window and coordinate sequence identical to the contiguous run, with each strobe exactly one cycle after its pixel.
- **Mid-frame restart:**
  - Stop the stream after pixel (9,8), then start a new frame with `pix_sof`.
  - No `frame_done` for the aborted frame.
  - No `window_valid` until new pixel (6,6), which produces values identical to the clean-frame case.
- **Async reset mid-frame:** assert `rst` between clock edges during row 7 → outputs drop to 0 before the next edge. A subsequent sof-less stream is indexed from (0,0) and produces 60 pulses.
